bitwise_reduce_stream: RTL and testbench



---
 rtl/bitwise_reduce_stream_if.sv | 29 ++
 rtl/bitwise_reduce_stream.sv | 104 ++++++++++
 tb/tb_bitwise_reduce_stream.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/bitwise_reduce_stream_if.sv
// Stream bundle for bitwise_reduce_stream: input beat channel plus result channel with flags.
// The master side produces beats and consumes results; the slave side is the reducer.
interface bitwise_reduce_stream_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic [1:0]       op;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_any;
    logic             out_zero;
    logic [CNT_W-1:0] out_count;
    logic             out_sat;

    modport master (
        output op, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_any, out_zero, out_count, out_sat
    );

    modport slave (
        input  op, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_any, out_zero, out_count, out_sat
    );
endinterface

// File: rtl/bitwise_reduce_stream.sv
// Folds a frame of WIDTH-bit beats with OR/AND/XOR/NOR chosen on the first beat,
// then presents the result with any/zero flags and a saturating beat count.
module bitwise_reduce_stream #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    bitwise_reduce_stream_if.slave  s
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0]       OP_AND  = 2'b01;
    localparam logic [1:0]       OP_XOR  = 2'b10;
    localparam logic [1:0]       OP_NOR  = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [CNT_W-1:0] count_reg;
    logic             sat_reg;
    logic [1:0]       opl_reg;
    logic             out_valid_reg;

    logic [WIDTH-1:0] fold_next;
    logic [WIDTH-1:0] result;
    logic             in_xfer;

    // NOR folds as OR and inverts only on the way out.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign fold_next[gi] = (opl_reg == OP_AND) ? (acc_reg[gi] & s.in_data[gi]) :
                                   (opl_reg == OP_XOR) ? (acc_reg[gi] ^ s.in_data[gi]) :
                                                         (acc_reg[gi] | s.in_data[gi]);
            assign result[gi]    = (opl_reg == OP_NOR) ? ~acc_reg[gi] : acc_reg[gi];
        end
    endgenerate

    assign s.in_ready  = !reset && (state_reg != DONE);
    assign in_xfer     = s.in_valid && s.in_ready;

    assign s.out_valid = out_valid_reg;
    assign s.out_data  = result;
    assign s.out_any   = |result;
    assign s.out_zero  = ~(|result);
    assign s.out_count = count_reg;
    assign s.out_sat   = sat_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            count_reg     <= '0;
            sat_reg       <= 1'b0;
            opl_reg       <= 2'b00;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_xfer) begin
                        acc_reg   <= s.in_data;
                        count_reg <= CNT_W'(1);
                        sat_reg   <= 1'b0;
                        opl_reg   <= s.op;
                        if (s.in_last) begin
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                        end else begin
                            state_reg     <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (in_xfer) begin
                        acc_reg <= fold_next;
                        if (count_reg == CNT_MAX) begin
                            sat_reg <= 1'b1;
                        end else begin
                            count_reg <= count_reg + CNT_W'(1);
                        end
                        if (s.in_last) begin
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (s.out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bitwise_reduce_stream.sv
// Runs an 8-bit-count and a 2-bit-count reducer in lockstep on the same beats and
// compares every result against a frame-level fold computed from the beat queue.
module tb_bitwise_reduce_stream;
    logic clk;
    logic reset;

    bitwise_reduce_stream_if #(.WIDTH(16), .CNT_W(8)) ifa ();
    bitwise_reduce_stream_if #(.WIDTH(16), .CNT_W(2)) ifb ();

    assign ifb.op        = ifa.op;
    assign ifb.in_valid  = ifa.in_valid;
    assign ifb.in_data   = ifa.in_data;
    assign ifb.in_last   = ifa.in_last;
    assign ifb.out_ready = ifa.out_ready;

    bitwise_reduce_stream #(.WIDTH(16), .CNT_W(8)) u_dut (
        .clk   (clk),
        .reset (reset),
        .s     (ifa)
    );

    bitwise_reduce_stream #(.WIDTH(16), .CNT_W(2)) u_dut_c2 (
        .clk   (clk),
        .reset (reset),
        .s     (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_frames = 0;
    logic [15:0] beats[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until the DUT takes it (bounded).
    task automatic send_beat(input logic [15:0] d, input logic last, input logic [1:0] o);
        logic ok;
        ifa.op       = o;
        ifa.in_data  = d;
        ifa.in_last  = last;
        ifa.in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            ok = ifa.in_ready;
            tick();
        end
        check("beat_accepted", 32'(ok), 32'd1);
    endtask

    function automatic logic [15:0] model_fold(input logic [1:0] opc);
        logic [15:0] r;
        r = beats[0];
        for (int i = 1; i < beats.size(); i++) begin
            case (opc)
                2'b01:   r = r & beats[i];
                2'b10:   r = r ^ beats[i];
                default: r = r | beats[i];
            endcase
        end
        return (opc == 2'b11) ? ~r : r;
    endfunction

    task automatic run_frame(input logic [1:0] opc, input int bp, input bit chg_op, input int gap);
        int          n;
        logic [15:0] exp_d;
        logic [1:0]  o;
        n     = beats.size();
        exp_d = model_fold(opc);
        for (int i = 0; i < n; i++) begin
            if (gap > 0 && i > 0) begin
                ifa.in_valid = 1'b0;
                repeat (gap) tick();
            end
            o = (i == 0 || !chg_op) ? opc : 2'($urandom);
            send_beat(beats[i], (i == n - 1), o);
        end
        // Junk beat offered while the result is pending must not be taken.
        ifa.in_valid = 1'b1;
        ifa.in_data  = 16'hDEAD;
        ifa.in_last  = 1'b1;
        ifa.op       = 2'($urandom);
        for (int c = 0; c <= bp; c++) begin
            ifa.out_ready = (c == bp);
            check("out_valid",   32'(ifa.out_valid), 32'd1);
            check("in_ready_0",  32'(ifa.in_ready),  32'd0);
            check("out_data",    32'(ifa.out_data),  32'(exp_d));
            check("out_any",     32'(ifa.out_any),   32'(exp_d != 16'h0));
            check("out_zero",    32'(ifa.out_zero),  32'(exp_d == 16'h0));
            check("out_count",   32'(ifa.out_count), 32'((n > 255) ? 255 : n));
            check("out_sat",     32'(ifa.out_sat),   32'(n > 255));
            check("c2_data",     32'(ifb.out_data),  32'(exp_d));
            check("c2_count",    32'(ifb.out_count), 32'((n > 3) ? 3 : n));
            check("c2_sat",      32'(ifb.out_sat),   32'(n > 3));
            check("c2_valid",    32'(ifb.out_valid), 32'd1);
            tick();
        end
        check("post_out_valid", 32'(ifa.out_valid), 32'd0);
        check("post_in_ready",  32'(ifa.in_ready),  32'd1);
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 1'b0;
        n_frames++;
        $display("frame %0d op=%0d beats=%0d exp=%h bp=%0d", n_frames, opc, n, exp_d, bp);
    endtask

    initial begin
        reset         = 1'b1;
        ifa.op        = 2'b00;
        ifa.in_valid  = 1'b0;
        ifa.in_data   = 16'h0;
        ifa.in_last   = 1'b0;
        ifa.out_ready = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", 32'(ifa.in_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("idle_in_ready",  32'(ifa.in_ready),  32'd1);
        check("idle_out_valid", 32'(ifa.out_valid), 32'd0);
        check("idle_out_data",  32'(ifa.out_data),  32'd0);
        check("idle_out_any",   32'(ifa.out_any),   32'd0);
        check("idle_out_zero",  32'(ifa.out_zero),  32'd1);
        check("idle_out_count", 32'(ifa.out_count), 32'd0);
        check("idle_out_sat",   32'(ifa.out_sat),   32'd0);
        tick();

        beats = {16'h0001, 16'h0F00, 16'h8000};
        run_frame(2'b00, 0, 1'b0, 0);
        beats = {16'hFFFF, 16'h00F0};
        run_frame(2'b01, 0, 1'b1, 0);
        beats = {16'hAAAA, 16'hAAAA};
        run_frame(2'b10, 0, 1'b0, 0);
        beats = {16'h00FF};
        run_frame(2'b11, 0, 1'b0, 0);
        beats = {16'h1234, 16'h4321};
        run_frame(2'b10, 5, 1'b0, 0);
        beats = {16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010};
        run_frame(2'b00, 0, 1'b0, 1);

        // Reset mid-frame, colliding with a last-beat transfer.
        ifa.out_ready = 1'b1;
        send_beat(16'h1234, 1'b0, 2'b10);
        send_beat(16'h00F0, 1'b0, 2'b10);
        ifa.in_data  = 16'hFFFF;
        ifa.in_last  = 1'b1;
        ifa.in_valid = 1'b1;
        reset        = 1'b1;
        #1;
        check("rst_mid_in_ready", 32'(ifa.in_ready), 32'd0);
        tick();
        reset        = 1'b0;
        ifa.in_valid = 1'b0;
        #1;
        check("rst_mid_out_valid", 32'(ifa.out_valid), 32'd0);
        check("rst_mid_out_count", 32'(ifa.out_count), 32'd0);
        check("rst_mid_out_zero",  32'(ifa.out_zero),  32'd1);
        check("rst_mid_in_ready1", 32'(ifa.in_ready),  32'd1);
        tick();
        check("rst_mid_still_idle", 32'(ifa.out_valid), 32'd0);
        ifa.out_ready = 1'b0;
        beats = {16'h0F0F, 16'hFF00};
        run_frame(2'b01, 1, 1'b0, 0);

        // Reset while a result is pending.
        send_beat(16'h5555, 1'b1, 2'b00);
        ifa.in_valid = 1'b0;
        check("done_before_rst", 32'(ifa.out_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("done_rst_out_valid", 32'(ifa.out_valid), 32'd0);
        check("done_rst_out_data",  32'(ifa.out_data),  32'd0);
        tick();

        for (int f = 0; f < 40; f++) begin
            int nb;
            nb = $urandom_range(1, 6);
            beats.delete();
            for (int i = 0; i < nb; i++) beats.push_back(16'($urandom));
            run_frame(2'($urandom), $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 2));
        end

        beats.delete();
        for (int i = 0; i < 258; i++) beats.push_back(16'(1 << (i % 16)) & 16'($urandom));
        run_frame(2'b00, 1, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
